// File: rtl/tile_map_pkg.sv
// Shared tile-map definitions: geometry, writer state encoding and the tile
// address function used by both the writer and the display fetch.
package tile_map_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int PIC_W  = 9;
    localparam int GRID_W = 32;
    localparam int GRID_H = 16;
    localparam int X_W    = 5;
    localparam int Y_W    = 4;
    localparam int W_W    = 6;
    localparam int H_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } tm_state_e;

    // start + x + y*row_length, wrapping modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] tile_addr(
        input logic [ADDR_W-1:0] start_address,
        input logic [ADDR_W-1:0] row_length,
        input logic [X_W-1:0]    x,
        input logic [Y_W-1:0]    y
    );
        logic [ADDR_W-1:0] row_offset;
        row_offset = row_length * {{(ADDR_W-Y_W){1'b0}}, y};
        return start_address + {{(ADDR_W-X_W){1'b0}}, x} + row_offset;
    endfunction

endpackage

// File: rtl/tile_rect_counter.sv
// Column/row walker for a rectangle clipped to the tile grid; flags empty
// rectangles at capture and the row-end / last-tile positions while walking.
module tile_rect_counter
    import tile_map_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] cmd_x,
    input  logic [Y_W-1:0] cmd_y,
    input  logic [W_W-1:0] cmd_width,
    input  logic [H_W-1:0] cmd_height,
    output logic           empty,
    output logic           row_end,
    output logic           last
);

    logic [W_W-1:0] eff_w_d, eff_w_q;
    logic [H_W-1:0] eff_h_d, eff_h_q;
    logic [X_W-1:0] col_d, col_q;
    logic [Y_W-1:0] row_d, row_q;
    logic [W_W-1:0] room_w, clip_w;
    logic [H_W-1:0] room_h, clip_h;

    // Clip the requested size against the space left in the grid
    always_comb begin
        room_w  = W_W'(GRID_W) - {1'b0, cmd_x};
        room_h  = H_W'(GRID_H) - {1'b0, cmd_y};
        clip_w  = (cmd_width  < room_w) ? cmd_width  : room_w;
        clip_h  = (cmd_height < room_h) ? cmd_height : room_h;
        empty   = (clip_w == 6'd0) || (clip_h == 5'd0);
        row_end = (({1'b0, col_q} + 6'd1) == eff_w_q);
        last    = row_end && (({1'b0, row_q} + 5'd1) == eff_h_q);
    end

    // Next column/row position
    always_comb begin
        eff_w_d = eff_w_q;
        eff_h_d = eff_h_q;
        col_d   = col_q;
        row_d   = row_q;
        if (load) begin
            eff_w_d = clip_w;
            eff_h_d = clip_h;
            col_d   = 5'd0;
            row_d   = 4'd0;
        end else if (advance) begin
            if (row_end) begin
                col_d = 5'd0;
                row_d = row_q + 4'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            eff_w_q <= 6'd0;
            eff_h_q <= 5'd0;
            col_q   <= 5'd0;
            row_q   <= 4'd0;
        end else begin
            eff_w_q <= eff_w_d;
            eff_h_q <= eff_h_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/tile_map_writer.sv
// Rectangle-fill writer for the tile map: walks a clipped rectangle and writes
// one picture number per tile through the arbitrated memory port.
module tile_map_writer
    import tile_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_start_address,
    input  logic [ADDR_W-1:0] cmd_row_length,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic [W_W-1:0]    cmd_width,
    input  logic [H_W-1:0]    cmd_height,
    input  logic [PIC_W-1:0]  cmd_pic_num,
    input  logic              cmd_incr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done
);

    tm_state_e         state_d, state_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] row_base_d, row_base_q;
    logic [ADDR_W-1:0] row_length_d, row_length_q;
    logic [PIC_W-1:0]  pic_d, pic_q;
    logic              incr_d, incr_q;
    logic              accept, advance, empty, row_end, last;

    assign accept  = cmd_valid && (state_q == ST_IDLE);
    assign advance = mem_ack && (state_q == ST_WRITE);

    tile_rect_counter u_rect (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .advance    (advance),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_width  (cmd_width),
        .cmd_height (cmd_height),
        .empty      (empty),
        .row_end    (row_end),
        .last       (last)
    );

    // FSM next state plus address / picture sequencing
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        row_length_d = row_length_q;
        pic_d        = pic_q;
        incr_d       = incr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d       = tile_addr(cmd_start_address, cmd_row_length, cmd_x, cmd_y);
                    row_base_d   = tile_addr(cmd_start_address, cmd_row_length, cmd_x, cmd_y);
                    row_length_d = cmd_row_length;
                    pic_d        = cmd_pic_num;
                    incr_d       = cmd_incr;
                    state_d      = empty ? ST_DONE : ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (advance) begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        // row_base tracks the first tile of the current row (x included)
                        if (row_end) begin
                            row_base_d = row_base_q + row_length_q;
                            addr_d     = row_base_q + row_length_q;
                        end else begin
                            addr_d = addr_q + 16'd1;
                        end
                        if (incr_q) begin
                            pic_d = pic_q + 9'd1;
                        end else begin
                            pic_d = pic_q;
                        end
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address and picture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 16'd0;
            row_base_q   <= 16'd0;
            row_length_q <= 16'd0;
            pic_q        <= 9'd0;
            incr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            row_length_q <= row_length_d;
            pic_q        <= pic_d;
            incr_q       <= incr_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign mem_we    = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = {{(DATA_W-PIC_W){1'b0}}, pic_q};

endmodule

// File: tb/tb_tile_map_writer.sv
// Self-checking bench for tile_map_writer: directed scenarios plus random
// rectangles, compared against a tile-list model built from grid arithmetic.
module tb_tile_map_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_start_address;
    logic [15:0] cmd_row_length;
    logic [4:0]  cmd_x;
    logic [3:0]  cmd_y;
    logic [5:0]  cmd_width;
    logic [4:0]  cmd_height;
    logic [8:0]  cmd_pic_num;
    logic        cmd_incr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] st;
        logic [15:0] rl;
        logic [4:0]  x;
        logic [3:0]  y;
        logic [5:0]  w;
        logic [4:0]  h;
        logic [8:0]  pic;
        logic        inc;
    } cmd_t;

    cmd_t nxt;

    tile_map_writer dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_start_address (cmd_start_address),
        .cmd_row_length    (cmd_row_length),
        .cmd_x             (cmd_x),
        .cmd_y             (cmd_y),
        .cmd_width         (cmd_width),
        .cmd_height        (cmd_height),
        .cmd_pic_num       (cmd_pic_num),
        .cmd_incr          (cmd_incr),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic drive(input cmd_t c);
        cmd_start_address = c.st;
        cmd_row_length    = c.rl;
        cmd_x             = c.x;
        cmd_y             = c.y;
        cmd_width         = c.w;
        cmd_height        = c.h;
        cmd_pic_num       = c.pic;
        cmd_incr          = c.inc;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.st  = 16'($urandom);
        c.rl  = 16'($urandom);
        c.x   = 5'($urandom);
        c.y   = 4'($urandom);
        c.w   = 6'($urandom_range(32));
        c.h   = 5'($urandom_range(16));
        c.pic = 9'($urandom);
        c.inc = 1'($urandom);
        return c;
    endfunction

    // Issue one command and follow it to completion; the expected tile list is
    // the clipped rectangle enumerated row by row.
    task automatic run_cmd(input cmd_t c, input int ack_pct, input int stall_idx,
                           input int stall_n, input bit keep_valid, input string name);
        logic [15:0] ea[$];
        logic [15:0] ed[$];
        int ew, eh, n, idx, cyc, stalls, budget, k;
        bit ack;
        ew = int'(c.w);
        if (ew > 32 - int'(c.x)) ew = 32 - int'(c.x);
        eh = int'(c.h);
        if (eh > 16 - int'(c.y)) eh = 16 - int'(c.y);
        k = 0;
        for (int r = 0; r < eh; r++) begin
            for (int cc = 0; cc < ew; cc++) begin
                ea.push_back(16'((int'(c.st) + int'(c.x) + cc + (int'(c.y) + r) * int'(c.rl)) % 65536));
                ed.push_back(c.inc ? 16'((int'(c.pic) + k) % 512) : {7'd0, c.pic});
                k++;
            end
        end
        n = ea.size();

        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
        end

        drive(c);
        cmd_valid = 1'b1;
        mem_ack   = 1'($urandom);
        @(posedge clk); #1;
        if (keep_valid) begin
            drive(nxt);
            cmd_valid = 1'b1;
        end else begin
            drive(rand_cmd());
            cmd_valid = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: got busy=%b ready=%b want busy=1 ready=0", name, busy, cmd_ready);
        end

        idx = 0; cyc = 0; stalls = 0; budget = n * 40 + 50;
        while (idx < n && cyc < budget) begin
            checks++;
            if (mem_we !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s we tile %0d: got we=%b done=%b want we=1 done=0", name, idx, mem_we, done);
                break;
            end
            checks++;
            if (mem_addr !== ea[idx]) begin
                failures++;
                $display("FAIL %s addr tile %0d: got %h want %h", name, idx, mem_addr, ea[idx]);
            end
            checks++;
            if (mem_wdata !== ed[idx]) begin
                failures++;
                $display("FAIL %s data tile %0d: got %h want %h", name, idx, mem_wdata, ed[idx]);
            end
            if (idx == stall_idx && stalls < stall_n) begin
                ack = 1'b0;
                stalls++;
            end else begin
                ack = ($urandom_range(99) < ack_pct);
            end
            mem_ack = ack;
            @(posedge clk); #1;
            if (ack) idx++;
            cyc++;
        end
        mem_ack = 1'($urandom);

        checks++;
        if (idx != n) begin
            failures++;
            $display("FAIL %s count: got %0d writes want %0d", name, idx, n);
        end
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s done: got done=%b we=%b busy=%b ready=%b want 1 0 1 0",
                     name, done, mem_we, busy, cmd_ready);
        end
        if (ack_pct == 100) begin
            checks++;
            if (cyc != n + stall_n) begin
                failures++;
                $display("FAIL %s cycles: got %0d want %0d", name, cyc, n + stall_n);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: got done=%b busy=%b ready=%b we=%b want 0 0 1 0",
                     name, done, busy, cmd_ready, mem_we);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        drive(rand_cmd());
        mem_ack   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset ctrl: got ready=%b we=%b busy=%b done=%b want 1 0 0 0",
                     cmd_ready, mem_we, busy, done);
        end
        checks++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset data: got addr=%h wdata=%h want 0000 0000", mem_addr, mem_wdata);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        mem_ack   = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset release: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        run_cmd('{st:16'h1000, rl:16'd32, x:5'd3, y:4'd2, w:6'd1, h:5'd1, pic:9'h005, inc:1'b0},
                100, -1, 0, 1'b0, "single");
    endtask

    task automatic test_incr_fill();
        run_cmd('{st:16'h2000, rl:16'd40, x:5'd0, y:4'd0, w:6'd3, h:5'd2, pic:9'h1FE, inc:1'b1},
                100, -1, 0, 1'b0, "incr_fill");
    endtask

    task automatic test_clip();
        run_cmd('{st:16'h0000, rl:16'd32, x:5'd30, y:4'd15, w:6'd5, h:5'd3, pic:9'h0AA, inc:1'b1},
                100, -1, 0, 1'b0, "clip");
    endtask

    task automatic test_backpressure();
        run_cmd('{st:16'h2000, rl:16'd40, x:5'd0, y:4'd0, w:6'd3, h:5'd2, pic:9'h1FE, inc:1'b1},
                100, 1, 4, 1'b0, "backpressure");
    endtask

    task automatic test_zero_and_busy();
        run_cmd('{st:16'h1234, rl:16'd32, x:5'd4, y:4'd4, w:6'd0, h:5'd5, pic:9'h011, inc:1'b0},
                100, -1, 0, 1'b0, "zero_w");
        run_cmd('{st:16'h1234, rl:16'd32, x:5'd4, y:4'd4, w:6'd5, h:5'd0, pic:9'h011, inc:1'b0},
                100, -1, 0, 1'b0, "zero_h");
        nxt = '{st:16'h5000, rl:16'd64, x:5'd7, y:4'd9, w:6'd2, h:5'd2, pic:9'h100, inc:1'b1};
        run_cmd('{st:16'h4000, rl:16'd16, x:5'd1, y:4'd1, w:6'd3, h:5'd2, pic:9'h020, inc:1'b1},
                100, -1, 0, 1'b1, "busy_first");
        run_cmd(nxt, 100, -1, 0, 1'b0, "busy_second");
    endtask

    task automatic test_full_fill();
        run_cmd('{st:16'hF000, rl:16'd32, x:5'd0, y:4'd0, w:6'd32, h:5'd16, pic:9'h000, inc:1'b1},
                100, -1, 0, 1'b0, "full_fill");
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] want_addr;
        cmd_t c;
        c = '{st:16'h3000, rl:16'd20, x:5'd2, y:4'd1, w:6'd4, h:5'd4, pic:9'h007, inc:1'b1};
        want_addr = 16'((int'(c.st) + int'(c.x) + 1 + int'(c.y) * int'(c.rl)) % 65536);
        drive(c);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mem_ack   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== want_addr) begin
            failures++;
            $display("FAIL midreset tile2: got we=%b addr=%h want 1 %h", mem_we, mem_addr, want_addr);
        end
        mem_ack   = 1'b0;
        reset     = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset abort: got we=%b busy=%b ready=%b done=%b want 0 0 1 0",
                     mem_we, busy, cmd_ready, done);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        mem_ack   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset quiet %0d: got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        mem_ack = 1'b0;
        run_cmd('{st:16'h0100, rl:16'd33, x:5'd5, y:4'd3, w:6'd3, h:5'd3, pic:9'h1F0, inc:1'b1},
                100, -1, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_cmd(rand_cmd(), int'($urandom_range(100, 30)), -1, 0, 1'b0, "random");
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        mem_ack   = 1'b0;
        drive('0);
        test_reset();
        test_single();
        test_incr_fill();
        test_clip();
        test_backpressure();
        test_zero_and_busy();
        test_full_fill();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_map_writer.md
Name: tile_map_writer

Overview:
- Write-side counterpart of the VGA tile-map fetch path. Receives rectangle-fill commands from the CPU/command decoder and writes picture numbers into tile-map memory.
- Uses the same addressing as the display fetch: address = start_address + x + y*row_length.
- Shares the tile-map memory port with the display reader through an external arbiter, which grants each write with mem_ack.
- Optional auto-increment of the picture number lets one command lay down a run of consecutive image-library tiles.

Parameters:
- ADDR_W, 16, memory address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, memory data width.
- PIC_W, 9, picture-number width; written into mem_wdata[PIC_W-1:0], upper bits zero.
- GRID_W, 32, super-pixel columns; x is 5 bits.
- GRID_H, 16, super-pixel rows; y is 4 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_start_address  in  16  tile-map top-left base address
- cmd_row_length  in  16  address stride per row
- cmd_x  in  5  rectangle left column
- cmd_y  in  4  rectangle top row
- cmd_width  in  6  columns, 0..32
- cmd_height  in  5  rows, 0..16
- cmd_pic_num  in  9  first picture number
- cmd_incr  in  1  1 = pic_num+1 after each tile written; 0 = constant fill
- mem_we  out  1  write request
- mem_addr  out  16  write address
- mem_wdata  out  16  {7'b0, pic}
- mem_ack  in  1  write accepted this cycle
- busy  out  1  high in WRITE and DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE, cmd_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0. All counters cleared.
- Reset mid-operation: the command is aborted on the next edge, mem_we drops, and no done pulse is produced.
- Handshake and capture: a command is accepted on the edge where cmd_valid && cmd_ready. On that edge all fields are registered; later input changes have no effect.
- Clipping at capture:
  - eff_w = min(cmd_width, GRID_W - cmd_x)
  - eff_h = min(cmd_height, GRID_H - cmd_y)
  - Tiles outside the 32x16 grid are never written.
- States:
  - IDLE: cmd_ready=1. On accept, go to DONE if eff_w==0 or eff_h==0, else go to WRITE.
  - WRITE: mem_we=1. mem_addr, mem_wdata, and all counters hold stable while mem_ack=0. On mem_ack:
    - If it was the last tile (col==eff_w-1 and row==eff_h-1), go to DONE.
    - Else if col==eff_w-1: col=0, row+1, row_base+=row_length, addr=row_base+row_length+x.
    - Else: col+1, addr+1.
    - In every non-final case, pic increments by 1 when cmd_incr=1 (wraps mod 512).
  - DONE: mem_we=0, done=1 for exactly one cycle, then IDLE. cmd_ready stays 0 in DONE.
- Address generation: the first address is start + x + y*row_length, computed once at capture. A single 16x4 multiply is allowed there. Row advance uses addition only, with no per-tile multiply.
- Latency:
  - First mem_we is asserted in the cycle after accept.
  - With mem_ack held high, one tile is written per cycle with no bubbles.
  - done is asserted in the cycle after the final ack.
  - A full 32x16 fill therefore takes 512 write cycles.
- Simultaneous events:
  - cmd_valid is ignored while busy.
  - When reset and cmd_valid are both high, reset wins.
  - mem_ack is ignored when mem_we=0.
- busy = (state != IDLE).

Decomposition:
- Shared package tile_map_pkg holds:
  - ADDR_W, DATA_W, PIC_W, GRID_W, GRID_H
  - the state encoding (IDLE=2'd0, WRITE=2'd1, DONE=2'd2)
  - the tile-address function (start + x + y*row_length), used by both this writer and the display fetch so the two cannot diverge.
- Sub-module tile_rect_counter handles col/row counting, clipping, and last-tile detection. The top level keeps the FSM, address and pic registers, and the memory port.

Test Plan:
- Single tile: start=0x1000, row_length=32, x=3, y=2, w=1, h=1, pic=0x05, incr=0, mem_ack=1 → one write, addr 0x1043, data 0x0005. done pulses in the cycle after the ack.
- 3x2 incrementing fill: start=0x2000, row_length=40, x=0, y=0, w=3, h=2, pic=0x1FE, incr=1 → writes in order:
  - addr 0x2000, 0x2001, 0x2002 with data 0x1FE, 0x1FF, 0x000
  - addr 0x2028, 0x2029, 0x202A with data 0x001, 0x002, 0x003
  - back-to-back, six cycles.
- Clipping: x=30, y=15, w=5, h=3, start=0, row_length=32 → exactly two writes, addr 0x01FE and 0x01FF, then done.
- Backpressure: during the 3x2 case, mem_ack is low for 4 cycles on the second tile → mem_addr and mem_wdata hold 0x2001/0x1FF unchanged, and the total write count remains 6.
- Zero size and busy: w=0 → no mem_we, done in the cycle after accept. A second cmd_valid raised while busy → not accepted until cmd_ready returns high.
- Reset mid-op: assert reset during the 2nd tile of a 4x4 fill → mem_we=0, busy=0, cmd_ready=1, no done pulse. A following new command executes correctly.
